// File: rtl/rx_iq_frame_scheduler.sv
// Pairs RX1/RX2 IQ samples into frames and buffers them in a 4-deep queue
// read by the MCU; iq_overrun records any dropped frame or lost sample.
module rx_iq_frame_scheduler (
    input  logic        clk_in,
    input  logic        reset_n,
    input  logic        rx1_valid,
    input  logic [23:0] RX1_I,
    input  logic [23:0] RX1_Q,
    input  logic        rx2_valid,
    input  logic [23:0] RX2_I,
    input  logic [23:0] RX2_Q,
    input  logic        rx2,
    input  logic        IQ_RX_READ_CLK,
    input  logic        overrun_clear,
    output logic [23:0] OUT_RX1_I,
    output logic [23:0] OUT_RX1_Q,
    output logic [23:0] OUT_RX2_I,
    output logic [23:0] OUT_RX2_Q,
    output logic        out_valid,
    output logic        iq_overrun,
    output logic [2:0]  fill_level
);

    typedef enum logic [1:0] {
        COLLECT_NONE = 2'd0,
        HAVE_RX1     = 2'd1,
        HAVE_RX2     = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;
    logic [23:0] hold1_i_r, hold1_q_r, hold2_i_r, hold2_q_r;
    logic        commit_s, latch1_s, latch2_s, fsm_ovr_s;
    logic [95:0] frame_s;

    logic [95:0] mem_r [0:3];
    logic [1:0]  wr_ptr_r, rd_ptr_r;
    logic [2:0]  count_r;
    logic        pop_s, full_s, write_s, drop_s, set_ovr_s;

    // Pairing FSM state register
    always_ff @(posedge clk_in) begin
        if (!reset_n) begin
            state_r <= COLLECT_NONE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Pairing FSM next state; dropping rx2 abandons any half-built pair
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            COLLECT_NONE: begin
                if (rx2 && rx1_valid && !rx2_valid) begin
                    state_nxt_s = HAVE_RX1;
                end else if (rx2 && rx2_valid && !rx1_valid) begin
                    state_nxt_s = HAVE_RX2;
                end else begin
                    state_nxt_s = COLLECT_NONE;
                end
            end
            HAVE_RX1: begin
                if (!rx2 || rx2_valid) begin
                    state_nxt_s = COLLECT_NONE;
                end else begin
                    state_nxt_s = HAVE_RX1;
                end
            end
            HAVE_RX2: begin
                if (!rx2 || rx1_valid) begin
                    state_nxt_s = COLLECT_NONE;
                end else begin
                    state_nxt_s = HAVE_RX2;
                end
            end
            default: state_nxt_s = COLLECT_NONE;
        endcase
    end

    // Pairing FSM outputs: frame commit, holding-register loads, lost-sample flag
    always_comb begin
        commit_s  = 1'b0;
        latch1_s  = 1'b0;
        latch2_s  = 1'b0;
        fsm_ovr_s = 1'b0;
        frame_s   = {RX1_I, RX1_Q, RX2_I, RX2_Q};
        case (state_r)
            COLLECT_NONE: begin
                if (!rx2) begin
                    commit_s = rx1_valid;
                    frame_s  = {RX1_I, RX1_Q, 48'd0};
                end else if (rx1_valid && rx2_valid) begin
                    commit_s = 1'b1;
                end else if (rx1_valid) begin
                    latch1_s = 1'b1;
                end else if (rx2_valid) begin
                    latch2_s = 1'b1;
                end else begin
                    commit_s = 1'b0;
                end
            end
            HAVE_RX1: begin
                frame_s = {hold1_i_r, hold1_q_r, RX2_I, RX2_Q};
                if (!rx2) begin
                    commit_s = 1'b0;
                end else if (rx2_valid) begin
                    commit_s  = 1'b1;
                    fsm_ovr_s = rx1_valid;
                end else if (rx1_valid) begin
                    latch1_s  = 1'b1;
                    fsm_ovr_s = 1'b1;
                end else begin
                    commit_s = 1'b0;
                end
            end
            HAVE_RX2: begin
                frame_s = {RX1_I, RX1_Q, hold2_i_r, hold2_q_r};
                if (!rx2) begin
                    commit_s = 1'b0;
                end else if (rx1_valid) begin
                    commit_s  = 1'b1;
                    fsm_ovr_s = rx2_valid;
                end else if (rx2_valid) begin
                    latch2_s  = 1'b1;
                    fsm_ovr_s = 1'b1;
                end else begin
                    commit_s = 1'b0;
                end
            end
            default: commit_s = 1'b0;
        endcase
    end

    // Per-channel holding registers for a half-collected pair
    always_ff @(posedge clk_in) begin
        if (!reset_n) begin
            hold1_i_r <= 24'd0;
            hold1_q_r <= 24'd0;
            hold2_i_r <= 24'd0;
            hold2_q_r <= 24'd0;
        end else begin
            if (latch1_s) begin
                hold1_i_r <= RX1_I;
                hold1_q_r <= RX1_Q;
            end
            if (latch2_s) begin
                hold2_i_r <= RX2_I;
                hold2_q_r <= RX2_Q;
            end
        end
    end

    // A pop is only honoured when the queue really holds a frame
    assign pop_s     = IQ_RX_READ_CLK && out_valid && (count_r != 3'd0);
    assign full_s    = (count_r == 3'd4);
    assign write_s   = commit_s && (!full_s || pop_s);
    assign drop_s    = commit_s && full_s && !pop_s;
    assign set_ovr_s = fsm_ovr_s || drop_s;

    // Circular frame queue: storage, pointers and occupancy
    always_ff @(posedge clk_in) begin
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) begin
                mem_r[i] <= 96'd0;
            end
            wr_ptr_r <= 2'd0;
            rd_ptr_r <= 2'd0;
            count_r  <= 3'd0;
        end else begin
            if (write_s) begin
                mem_r[wr_ptr_r] <= frame_s;
                wr_ptr_r        <= wr_ptr_r + 2'd1;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + 2'd1;
            end
            case ({write_s, pop_s})
                2'b10:   count_r <= count_r + 3'd1;
                2'b01:   count_r <= count_r - 3'd1;
                default: count_r <= count_r;
            endcase
        end
    end

    // Head-of-queue output register; holds the last frame once the queue drains
    always_ff @(posedge clk_in) begin
        if (!reset_n) begin
            {OUT_RX1_I, OUT_RX1_Q, OUT_RX2_I, OUT_RX2_Q} <= 96'd0;
            out_valid <= 1'b0;
        end else if (count_r != 3'd0) begin
            {OUT_RX1_I, OUT_RX1_Q, OUT_RX2_I, OUT_RX2_Q} <= mem_r[rd_ptr_r];
            out_valid <= 1'b1;
        end else begin
            out_valid <= 1'b0;
        end
    end

    // Sticky overrun flag; a new event outranks a clear in the same cycle
    always_ff @(posedge clk_in) begin
        if (!reset_n) begin
            iq_overrun <= 1'b0;
        end else if (set_ovr_s) begin
            iq_overrun <= 1'b1;
        end else if (overrun_clear) begin
            iq_overrun <= 1'b0;
        end else begin
            iq_overrun <= iq_overrun;
        end
    end

    assign fill_level = count_r;

endmodule

// File: tb/tb_rx_iq_frame_scheduler.sv
// Directed self-checking bench for rx_iq_frame_scheduler.
module tb_rx_iq_frame_scheduler;

    logic        clk_in = 1'b0;
    logic        reset_n = 1'b0;
    logic        rx1_valid = 1'b0, rx2_valid = 1'b0, rx2 = 1'b0;
    logic [23:0] RX1_I = 24'd0, RX1_Q = 24'd0, RX2_I = 24'd0, RX2_Q = 24'd0;
    logic        IQ_RX_READ_CLK = 1'b0, overrun_clear = 1'b0;
    logic [23:0] OUT_RX1_I, OUT_RX1_Q, OUT_RX2_I, OUT_RX2_Q;
    logic        out_valid, iq_overrun;
    logic [2:0]  fill_level;

    int n_vec = 0;
    int n_err = 0;

    rx_iq_frame_scheduler dut (
        .clk_in(clk_in), .reset_n(reset_n),
        .rx1_valid(rx1_valid), .RX1_I(RX1_I), .RX1_Q(RX1_Q),
        .rx2_valid(rx2_valid), .RX2_I(RX2_I), .RX2_Q(RX2_Q),
        .rx2(rx2), .IQ_RX_READ_CLK(IQ_RX_READ_CLK), .overrun_clear(overrun_clear),
        .OUT_RX1_I(OUT_RX1_I), .OUT_RX1_Q(OUT_RX1_Q),
        .OUT_RX2_I(OUT_RX2_I), .OUT_RX2_Q(OUT_RX2_Q),
        .out_valid(out_valid), .iq_overrun(iq_overrun), .fill_level(fill_level)
    );

    always #5 clk_in = ~clk_in;

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic send_rx1(input logic [23:0] i, input logic [23:0] q);
        RX1_I = i; RX1_Q = q; rx1_valid = 1'b1;
        tick();
        rx1_valid = 1'b0;
    endtask

    task automatic send_rx2(input logic [23:0] i, input logic [23:0] q);
        RX2_I = i; RX2_Q = q; rx2_valid = 1'b1;
        tick();
        rx2_valid = 1'b0;
    endtask

    task automatic pop_one();
        IQ_RX_READ_CLK = 1'b1;
        tick();
        IQ_RX_READ_CLK = 1'b0;
        tick();
    endtask

    task automatic clear_flag();
        overrun_clear = 1'b1;
        tick();
        overrun_clear = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        tick(); tick();
        n_vec++; if (fill_level !== 3'd0) begin n_err++; $display("FAIL rst_fill got %0d exp 0", fill_level); end
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got %b exp 0", out_valid); end
        n_vec++; if (iq_overrun !== 1'b0) begin n_err++; $display("FAIL rst_ovr got %b exp 0", iq_overrun); end
        n_vec++; if (OUT_RX1_I !== 24'd0) begin n_err++; $display("FAIL rst_out got %h exp 0", OUT_RX1_I); end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_rx1_only();
        rx2 = 1'b0;
        send_rx1(24'h123456, 24'hFEDCBA);
        tick();
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL r1_valid got %b exp 1", out_valid); end
        n_vec++; if (OUT_RX1_I !== 24'h123456) begin n_err++; $display("FAIL r1_i got %h exp 123456", OUT_RX1_I); end
        n_vec++; if (OUT_RX1_Q !== 24'hFEDCBA) begin n_err++; $display("FAIL r1_q got %h exp fedcba", OUT_RX1_Q); end
        n_vec++; if (OUT_RX2_I !== 24'd0) begin n_err++; $display("FAIL r1_r2i got %h exp 0", OUT_RX2_I); end
        n_vec++; if (fill_level !== 3'd1) begin n_err++; $display("FAIL r1_fill got %0d exp 1", fill_level); end
        pop_one();
        n_vec++; if (fill_level !== 3'd0) begin n_err++; $display("FAIL r1_pop_fill got %0d exp 0", fill_level); end
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL r1_pop_valid got %b exp 0", out_valid); end
        n_vec++; if (OUT_RX1_I !== 24'h123456) begin n_err++; $display("FAIL r1_hold got %h exp 123456", OUT_RX1_I); end
    endtask

    task automatic test_pairing();
        rx2 = 1'b1;
        send_rx2(24'h000010, 24'h000011);
        tick(); tick(); tick();
        send_rx1(24'h000020, 24'h000021);
        tick();
        n_vec++; if (OUT_RX1_I !== 24'h20) begin n_err++; $display("FAIL pair_r1 got %h exp 20", OUT_RX1_I); end
        n_vec++; if (OUT_RX2_I !== 24'h10) begin n_err++; $display("FAIL pair_r2 got %h exp 10", OUT_RX2_I); end
        n_vec++; if (OUT_RX2_Q !== 24'h11) begin n_err++; $display("FAIL pair_r2q got %h exp 11", OUT_RX2_Q); end
        n_vec++; if (iq_overrun !== 1'b0) begin n_err++; $display("FAIL pair_ovr got %b exp 0", iq_overrun); end
        n_vec++; if (fill_level !== 3'd1) begin n_err++; $display("FAIL pair_fill got %0d exp 1", fill_level); end
        pop_one();
    endtask

    task automatic test_overwrite();
        rx2 = 1'b1;
        send_rx1(24'h000031, 24'h0);
        send_rx1(24'h000032, 24'h0);
        send_rx2(24'h000040, 24'h0);
        tick();
        n_vec++; if (iq_overrun !== 1'b1) begin n_err++; $display("FAIL ow_ovr got %b exp 1", iq_overrun); end
        n_vec++; if (OUT_RX1_I !== 24'h32) begin n_err++; $display("FAIL ow_r1 got %h exp 32", OUT_RX1_I); end
        n_vec++; if (OUT_RX2_I !== 24'h40) begin n_err++; $display("FAIL ow_r2 got %h exp 40", OUT_RX2_I); end
        n_vec++; if (fill_level !== 3'd1) begin n_err++; $display("FAIL ow_fill got %0d exp 1", fill_level); end
        clear_flag();
        n_vec++; if (iq_overrun !== 1'b0) begin n_err++; $display("FAIL ow_clr got %b exp 0", iq_overrun); end
        pop_one();
    endtask

    task automatic test_discard_and_priority();
        rx2 = 1'b1;
        send_rx1(24'h000070, 24'h0);
        RX1_I = 24'h000071; rx1_valid = 1'b1; overrun_clear = 1'b1;
        tick();
        rx1_valid = 1'b0; overrun_clear = 1'b0;
        n_vec++; if (iq_overrun !== 1'b1) begin n_err++; $display("FAIL prio_set got %b exp 1", iq_overrun); end
        clear_flag();
        n_vec++; if (iq_overrun !== 1'b0) begin n_err++; $display("FAIL prio_clr got %b exp 0", iq_overrun); end
        rx2 = 1'b0;
        tick();
        n_vec++; if (fill_level !== 3'd0) begin n_err++; $display("FAIL disc_fill got %0d exp 0", fill_level); end
        n_vec++; if (iq_overrun !== 1'b0) begin n_err++; $display("FAIL disc_ovr got %b exp 0", iq_overrun); end
        rx2 = 1'b1;
        send_rx2(24'h000061, 24'h0);
        send_rx1(24'h000062, 24'h0);
        tick();
        n_vec++; if (OUT_RX1_I !== 24'h62) begin n_err++; $display("FAIL disc_r1 got %h exp 62", OUT_RX1_I); end
        n_vec++; if (OUT_RX2_I !== 24'h61) begin n_err++; $display("FAIL disc_r2 got %h exp 61", OUT_RX2_I); end
        n_vec++; if (fill_level !== 3'd1) begin n_err++; $display("FAIL disc_fill2 got %0d exp 1", fill_level); end
        pop_one();
        rx2 = 1'b0;
    endtask

    task automatic test_full();
        rx2 = 1'b0;
        for (int k = 1; k <= 5; k++) send_rx1(24'(k), 24'h0);
        tick();
        n_vec++; if (fill_level !== 3'd4) begin n_err++; $display("FAIL full_fill got %0d exp 4", fill_level); end
        n_vec++; if (iq_overrun !== 1'b1) begin n_err++; $display("FAIL full_ovr got %b exp 1", iq_overrun); end
        clear_flag();
        for (int k = 1; k <= 4; k++) begin
            n_vec++; if (OUT_RX1_I !== 24'(k)) begin n_err++; $display("FAIL full_order got %h exp %h", OUT_RX1_I, 24'(k)); end
            pop_one();
        end
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL full_empty got %b exp 0", out_valid); end
        pop_one();
        n_vec++; if (fill_level !== 3'd0) begin n_err++; $display("FAIL empty_pop_fill got %0d exp 0", fill_level); end
        n_vec++; if (iq_overrun !== 1'b0) begin n_err++; $display("FAIL empty_pop_ovr got %b exp 0", iq_overrun); end
        n_vec++; if (OUT_RX1_I !== 24'd4) begin n_err++; $display("FAIL empty_pop_hold got %h exp 4", OUT_RX1_I); end
    endtask

    task automatic test_back_to_back();
        logic [23:0] model[$];
        rx2 = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            send_rx1(24'h100 + 24'(k), 24'h0);
            model.push_back(24'h100 + 24'(k));
        end
        tick();
        n_vec++; if (fill_level !== 3'd4) begin n_err++; $display("FAIL b2b_fill0 got %0d exp 4", fill_level); end
        for (int j = 0; j < 8; j++) begin
            n_vec++; if (OUT_RX1_I !== model[0]) begin n_err++; $display("FAIL b2b_head got %h exp %h", OUT_RX1_I, model[0]); end
            RX1_I = 24'h200 + 24'(j); rx1_valid = 1'b1; IQ_RX_READ_CLK = 1'b1;
            tick();
            rx1_valid = 1'b0; IQ_RX_READ_CLK = 1'b0;
            tick();
            void'(model.pop_front());
            model.push_back(24'h200 + 24'(j));
            n_vec++; if (fill_level !== 3'd4) begin n_err++; $display("FAIL b2b_fill got %0d exp 4", fill_level); end
            n_vec++; if (iq_overrun !== 1'b0) begin n_err++; $display("FAIL b2b_ovr got %b exp 0", iq_overrun); end
        end
        for (int j = 0; j < 4; j++) begin
            n_vec++; if (OUT_RX1_I !== model[0]) begin n_err++; $display("FAIL b2b_drain got %h exp %h", OUT_RX1_I, model[0]); end
            pop_one();
            void'(model.pop_front());
        end
        n_vec++; if (fill_level !== 3'd0) begin n_err++; $display("FAIL b2b_end got %0d exp 0", fill_level); end
    endtask

    task automatic test_reset_midqueue();
        rx2 = 1'b0;
        for (int k = 1; k <= 3; k++) send_rx1(24'hA0 + 24'(k), 24'h0);
        tick();
        n_vec++; if (fill_level !== 3'd3) begin n_err++; $display("FAIL mid_fill got %0d exp 3", fill_level); end
        rx2 = 1'b1;
        send_rx1(24'h000099, 24'h0);
        reset_n = 1'b0; IQ_RX_READ_CLK = 1'b1; rx1_valid = 1'b1; RX1_I = 24'h55;
        tick();
        IQ_RX_READ_CLK = 1'b0; rx1_valid = 1'b0;
        n_vec++; if (fill_level !== 3'd0) begin n_err++; $display("FAIL mid_rst_fill got %0d exp 0", fill_level); end
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_rst_valid got %b exp 0", out_valid); end
        n_vec++; if (OUT_RX1_I !== 24'd0) begin n_err++; $display("FAIL mid_rst_out got %h exp 0", OUT_RX1_I); end
        n_vec++; if (iq_overrun !== 1'b0) begin n_err++; $display("FAIL mid_rst_ovr got %b exp 0", iq_overrun); end
        reset_n = 1'b1; rx2 = 1'b0;
        send_rx1(24'hABCDEF, 24'h012345);
        n_vec++; if (fill_level !== 3'd1) begin n_err++; $display("FAIL rel_fill got %0d exp 1", fill_level); end
        tick();
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL rel_valid got %b exp 1", out_valid); end
        n_vec++; if (OUT_RX1_I !== 24'hABCDEF) begin n_err++; $display("FAIL rel_r1 got %h exp abcdef", OUT_RX1_I); end
        n_vec++; if (OUT_RX2_I !== 24'd0) begin n_err++; $display("FAIL rel_r2 got %h exp 0", OUT_RX2_I); end
    endtask

    initial begin
        test_reset();
        test_rx1_only();
        test_pairing();
        test_overwrite();
        test_discard_and_priority();
        test_full();
        test_back_to_back();
        test_reset_midqueue();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rx_iq_frame_scheduler.md
RX_IQ_FRAME_SCHEDULER -- requirements
Module: rx_iq_frame_scheduler

Interface
REQ-001 clk_in  input  1  system clock; all logic SHALL be on its rising edge.
REQ-002 reset_n  input  1  reset, synchronous and active-low.
REQ-003 rx1_valid  input  1  one-cycle strobe; a new RX1 sample is present on RX1_I/RX1_Q.
REQ-004 RX1_I, RX1_Q  input  24 each  signed RX1 baseband sample.
REQ-005 rx2_valid  input  1  one-cycle strobe; a new RX2 sample is present on RX2_I/RX2_Q.
REQ-006 RX2_I, RX2_Q  input  24 each  signed RX2 baseband sample.
REQ-007 rx2  input  1  RX2 enable; 1 means a frame = RX1+RX2 sample pair, 0 means a frame = RX1 only.
REQ-008 IQ_RX_READ_CLK  input  1  one-cycle pop strobe from the MCU bus interface.
REQ-009 overrun_clear  input  1  one-cycle strobe that clears iq_overrun.
REQ-010 OUT_RX1_I, OUT_RX1_Q, OUT_RX2_I, OUT_RX2_Q  output  24 each  head-of-queue frame.
REQ-011 out_valid  output  1  queue non-empty; OUT_* holds a valid frame.
REQ-012 iq_overrun  output  1  sticky flag for a dropped frame or a lost sample.
REQ-013 fill_level  output  3  number of queued frames, 0..4.

Function
REQ-014 A pairing FSM SHALL have the states COLLECT_NONE, HAVE_RX1 and HAVE_RX2, plus per-channel holding registers.
REQ-015 COLLECT_NONE transitions:
- rx1_valid & !rx2: commit an RX1-only frame (RX2 fields = 0) and stay in COLLECT_NONE.
- rx1_valid & rx2_valid & rx2: commit the pair and stay in COLLECT_NONE.
- rx1_valid only with rx2=1: latch RX1 and go to HAVE_RX1.
- rx2_valid only with rx2=1: latch RX2 and go to HAVE_RX2.
- rx2_valid with rx2=0: ignore.
REQ-016 HAVE_RX1 transitions:
- rx2_valid: commit the pair and go to COLLECT_NONE.
- rx1_valid without rx2_valid: overwrite the held RX1, set iq_overrun, stay.
REQ-017 HAVE_RX2 behaves symmetrically to REQ-016 with the roles of RX1 and RX2 swapped.
REQ-018 When rx2 drops to 0 while in HAVE_RX1 or HAVE_RX2, the FSM SHALL discard the partial frame and enter COLLECT_NONE on the next edge; iq_overrun SHALL NOT be set.
REQ-019 Committed frames SHALL enter a 4-entry, 96-bit circular queue with 2-bit write and read pointers that wrap 3->0.
REQ-020 Latency: a frame committed on edge N SHALL be visible on OUT_* with out_valid=1 at edge N+1 when the queue was empty. OUT_* is registered from the head entry.
REQ-021 Pop: IQ_RX_READ_CLK=1 with out_valid=1 SHALL advance the read pointer. The next frame SHALL appear on OUT_* one cycle later.
REQ-022 Pop on an empty queue SHALL be ignored: no pointer change, no flag. OUT_* SHALL hold the last value.
REQ-023 A commit with fill_level=4 and no simultaneous pop SHALL drop the new frame, leave the queue unchanged and set iq_overrun.
REQ-024 A simultaneous commit and pop with fill_level=4 SHALL perform both; fill_level stays 4 and no overrun is flagged.
REQ-025 A simultaneous commit and pop with fill_level of 1..3 SHALL perform both; fill_level is unchanged.
REQ-026 Flag priority for iq_overrun:
- set and overrun_clear in the same cycle: the flag ends at 1 (set wins).
- otherwise overrun_clear forces it to 0.
REQ-027 Samples SHALL be stored unmodified; no sign extension, rounding or reordering.

Reset
REQ-028 With reset_n=0 at an edge, the block SHALL enter this state, overriding all other inputs:
- FSM: COLLECT_NONE.
- Pointers: 0.
- Outputs: fill_level=0, out_valid=0, iq_overrun=0, OUT_*=0.
REQ-029 A partial frame or queued frames present at reset SHALL be discarded. Reset mid-pop SHALL leave no residual pop effect.
REQ-030 Strobes asserted in the cycle reset is released SHALL be processed normally.

Verification
REQ-031 rx2=0, rx1_valid with RX1_I=0x123456, RX1_Q=0xFEDCBA -> next cycle out_valid=1, OUT_RX1_I=0x123456, OUT_RX2_I=0, fill_level=1.
REQ-032 rx2=1, rx2_valid (RX2_I=0x000010) then 3 cycles later rx1_valid (RX1_I=0x000020) -> one frame, OUT_RX1_I=0x20, OUT_RX2_I=0x10, iq_overrun=0.
REQ-033 rx2=1, two rx1_valid before any rx2_valid -> iq_overrun=1; the committed frame holds the second RX1 sample.
REQ-034 Five RX1-only commits with no pops -> fill_level=4, iq_overrun=1. Four pops return the frames 1-4 in order; a further pop is ignored.
REQ-035 Queue full with commit and pop in the same cycle -> fill_level stays 4, no overrun. The pointers wrap correctly across 8 pops.
REQ-036 HAVE_RX1 with rx2 cleared -> partial frame discarded, fill_level unchanged. reset_n=0 with 3 frames queued -> fill_level=0, out_valid=0 next cycle.
